// File: rtl/multi_wav_player.sv
// Multi-voice PCM player: voices share one registered-output ROM port through a
// round-robin IDLE/ISSUE/CAPTURE fetch FSM, then are mixed, shifted and saturated.
module multi_wav_player #(
  parameter int CHANNELS = 4,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int DIV_W    = 12,
  parameter int VOL_W    = 2,
  parameter int OUT_W    = 16,
  parameter int SHIFT    = 6,
  localparam int CHAN_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                I_CLK,
  input  logic                I_RSTn,
  input  logic                I_CMD_VALID,
  input  logic [CHAN_W-1:0]   I_CMD_CHAN,
  input  logic                I_CMD_START,
  input  logic [ADDR_W-1:0]   I_CMD_ADDR,
  input  logic [ADDR_W-1:0]   I_CMD_LEN,
  input  logic [DIV_W-1:0]    I_CMD_DIV,
  input  logic [VOL_W-1:0]    I_CMD_VOL,
  input  logic                I_CMD_LOOP,
  output logic [ADDR_W-1:0]   O_ROM_ADDR,
  output logic                O_ROM_RD,
  input  logic [DATA_W-1:0]   I_ROM_DATA,
  output logic [CHANNELS-1:0] O_BUSY,
  output logic [CHANNELS-1:0] O_DONE,
  output logic [OUT_W-1:0]    O_SND
);

  localparam int ACC_W  = DATA_W + VOL_W + 2 + $clog2(CHANNELS + 1);
  localparam int SH_W0  = ACC_W + SHIFT;
  localparam int SH_W   = (SH_W0 > OUT_W) ? SH_W0 : OUT_W + 1;
  localparam longint MAX_L = (longint'(1) << (OUT_W - 1)) - 1;
  localparam longint MIN_L = -(longint'(1) << (OUT_W - 1));
  localparam logic signed [SH_W-1:0] SAT_MAX = SH_W'(MAX_L);
  localparam logic signed [SH_W-1:0] SAT_MIN = SH_W'(MIN_L);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE} state_t;

  state_t                   state_q;
  logic [CHAN_W-1:0]        cur_q, last_q;
  logic                     kill_q;
  logic [ADDR_W-1:0]        rom_addr_q;
  logic                     rom_rd_q;
  logic [CHANNELS-1:0]      busy_q, pend_q, hold_q, done_q, loop_q;
  logic [ADDR_W-1:0]        base_q [CHANNELS];
  logic [ADDR_W-1:0]        len_q  [CHANNELS];
  logic [ADDR_W-1:0]        ptr_q  [CHANNELS];
  logic [DIV_W-1:0]         div_q  [CHANNELS];
  logic [DIV_W-1:0]         presc_q[CHANNELS];
  logic [VOL_W-1:0]         vol_q  [CHANNELS];
  logic signed [DATA_W-1:0] sample_q[CHANNELS];
  logic [OUT_W-1:0]         snd_q;

  logic [CHANNELS-1:0]      wrap_d;
  logic                     sel_found_d, kill_any_d;
  logic [CHAN_W-1:0]        sel_chan_d;
  logic [ADDR_W-1:0]        sel_addr_d;
  logic signed [ACC_W-1:0]  term_d [CHANNELS];
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [SH_W-1:0]   sh_d;
  logic [OUT_W-1:0]         snd_d;
  int                       idx;

  // Prescaler keeps running through the one-period hold of a finished one-shot voice.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      wrap_d[c] = (busy_q[c] | hold_q[c]) && (presc_q[c] == div_q[c]);
    end
  end

  assign kill_any_d = kill_q | (I_CMD_VALID && (I_CMD_CHAN == cur_q));

  // Round-robin pick: first pending voice strictly after the last one served.
  always_comb begin
    sel_found_d = 1'b0;
    sel_chan_d  = '0;
    sel_addr_d  = '0;
    idx         = 0;
    for (int k = 1; k <= CHANNELS; k++) begin
      idx = (int'(last_q) + k) % CHANNELS;
      for (int c = 0; c < CHANNELS; c++) begin
        if (!sel_found_d && (c == idx) && pend_q[c]) begin
          sel_found_d = 1'b1;
          sel_chan_d  = CHAN_W'(c);
          sel_addr_d  = base_q[c] + ptr_q[c];
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_mix
      assign term_d[gi] = (busy_q[gi] | hold_q[gi])
                        ? $signed(ACC_W'(sample_q[gi])) * $signed(ACC_W'({1'b0, vol_q[gi]}))
                        : '0;
    end
  endgenerate

  always_comb begin
    acc_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      acc_d = acc_d + term_d[c];
    end
    sh_d = SH_W'(acc_d) <<< SHIFT;
    if (sh_d > SAT_MAX)      snd_d = SAT_MAX[OUT_W-1:0];
    else if (sh_d < SAT_MIN) snd_d = SAT_MIN[OUT_W-1:0];
    else                     snd_d = sh_d[OUT_W-1:0];
  end

  always_ff @(posedge I_CLK) begin
    if (!I_RSTn) begin
      state_q    <= S_IDLE;
      cur_q      <= '0;
      last_q     <= CHAN_W'(CHANNELS - 1);
      kill_q     <= 1'b0;
      rom_addr_q <= '0;
      rom_rd_q   <= 1'b0;
      busy_q     <= '0;
      pend_q     <= '0;
      hold_q     <= '0;
      done_q     <= '0;
      loop_q     <= '0;
      snd_q      <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        base_q[c]   <= '0;
        len_q[c]    <= '0;
        ptr_q[c]    <= '0;
        div_q[c]    <= '0;
        presc_q[c]  <= '0;
        vol_q[c]    <= '0;
        sample_q[c] <= '0;
      end
    end else begin
      done_q   <= '0;
      rom_rd_q <= 1'b0;
      snd_q    <= snd_d;

      for (int c = 0; c < CHANNELS; c++) begin
        if (busy_q[c] | hold_q[c]) begin
          if (wrap_d[c]) begin
            presc_q[c] <= '0;
            if (busy_q[c]) pend_q[c] <= 1'b1;
            if (hold_q[c]) begin
              hold_q[c]   <= 1'b0;
              sample_q[c] <= '0;
            end
          end else begin
            presc_q[c] <= presc_q[c] + DIV_W'(1);
          end
        end
      end

      case (state_q)
        S_IDLE: begin
          if (sel_found_d) begin
            cur_q      <= sel_chan_d;
            rom_rd_q   <= 1'b1;
            rom_addr_q <= sel_addr_d;
            kill_q     <= I_CMD_VALID && (I_CMD_CHAN == sel_chan_d);
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // A request raised by a wrap or a command this cycle is kept for a later fetch.
          for (int c = 0; c < CHANNELS; c++) begin
            if ((CHAN_W'(c) == cur_q) && !kill_any_d && !(wrap_d[c] && busy_q[c])) begin
              pend_q[c] <= 1'b0;
            end
          end
          kill_q  <= kill_any_d;
          state_q <= S_CAPTURE;
        end
        S_CAPTURE: begin
          for (int c = 0; c < CHANNELS; c++) begin
            if ((CHAN_W'(c) == cur_q) && !kill_any_d) begin
              sample_q[c] <= {~I_ROM_DATA[DATA_W-1], I_ROM_DATA[DATA_W-2:0]};
              if (ptr_q[c] == len_q[c] - ADDR_W'(1)) begin
                ptr_q[c] <= '0;
                if (!loop_q[c]) begin
                  busy_q[c] <= 1'b0;
                  pend_q[c] <= 1'b0;
                  hold_q[c] <= 1'b1;
                  done_q[c] <= 1'b1;
                end
              end else begin
                ptr_q[c] <= ptr_q[c] + ADDR_W'(1);
              end
            end
          end
          last_q  <= cur_q;
          kill_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      // Commands are applied last so they override any fetch bookkeeping this cycle.
      for (int c = 0; c < CHANNELS; c++) begin
        if (I_CMD_VALID && (I_CMD_CHAN == CHAN_W'(c))) begin
          if (I_CMD_START && (I_CMD_LEN != '0)) begin
            base_q[c]  <= I_CMD_ADDR;
            len_q[c]   <= I_CMD_LEN;
            div_q[c]   <= I_CMD_DIV;
            vol_q[c]   <= I_CMD_VOL;
            loop_q[c]  <= I_CMD_LOOP;
            ptr_q[c]   <= '0;
            presc_q[c] <= '0;
            busy_q[c]  <= 1'b1;
            pend_q[c]  <= 1'b1;
            hold_q[c]  <= 1'b0;
          end else begin
            busy_q[c]   <= 1'b0;
            pend_q[c]   <= 1'b0;
            hold_q[c]   <= 1'b0;
            sample_q[c] <= '0;
          end
        end
      end
    end
  end

  assign O_ROM_ADDR = rom_addr_q;
  assign O_ROM_RD   = rom_rd_q;
  assign O_BUSY     = busy_q;
  assign O_DONE     = done_q;
  assign O_SND      = snd_q;

endmodule

// File: tb/tb_multi_wav_player.sv
// Scoreboard bench for multi_wav_player: stimulus queues expected fetch addresses,
// mixer output changes and done pulses; a monitor pops and compares each DUT event.
`timescale 1ns/1ps
module tb_multi_wav_player;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_start, cmd_loop;
  logic [1:0]  cmd_chan, cmd_vol;
  logic [15:0] cmd_addr, cmd_len;
  logic [11:0] cmd_div;
  logic [15:0] rom_addr;
  logic        rom_rd;
  logic [7:0]  rom_data = 8'h00;
  logic [3:0]  busy, done;
  logic [15:0] snd;

  logic [7:0]  rom [65536];
  int          compared = 0;
  int          mismatched = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  int          snd_prev = 0;
  logic [15:0] exp_addr[$];
  int          exp_snd[$];
  logic [3:0]  exp_done[$];
  int          rd_times[$];
  logic [15:0] ea;
  int          es;
  logic [3:0]  ed;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rom_rd) rom_data <= rom[rom_addr];

  multi_wav_player dut (
    .I_CLK(clk), .I_RSTn(rst_n),
    .I_CMD_VALID(cmd_valid), .I_CMD_CHAN(cmd_chan), .I_CMD_START(cmd_start),
    .I_CMD_ADDR(cmd_addr), .I_CMD_LEN(cmd_len), .I_CMD_DIV(cmd_div),
    .I_CMD_VOL(cmd_vol), .I_CMD_LOOP(cmd_loop),
    .O_ROM_ADDR(rom_addr), .O_ROM_RD(rom_rd), .I_ROM_DATA(rom_data),
    .O_BUSY(busy), .O_DONE(done), .O_SND(snd)
  );

  task automatic check(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  // Monitor: one line per observed fetch, output change or done pulse.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (rom_rd === 1'b1) begin
          rd_times.push_back(cyc);
          compared++;
          if (exp_addr.size() == 0) begin
            mismatched++;
            $display("FAIL rom_addr: got fetch at %h, required no fetch", rom_addr);
          end else begin
            ea = exp_addr.pop_front();
            if (rom_addr !== ea) begin
              mismatched++;
              $display("FAIL rom_addr: got %h required %h", rom_addr, ea);
            end else $display("fetch ok  addr=%h cycle=%0d", rom_addr, cyc);
          end
        end
        if (int'($signed(snd)) != snd_prev) begin
          compared++;
          if (exp_snd.size() == 0) begin
            mismatched++;
            $display("FAIL snd: got change to %0d, required no change", $signed(snd));
          end else begin
            es = exp_snd.pop_front();
            if (int'($signed(snd)) != es) begin
              mismatched++;
              $display("FAIL snd: got %0d required %0d", $signed(snd), es);
            end else $display("snd ok    value=%0d cycle=%0d", $signed(snd), cyc);
          end
        end
        if (done !== 4'b0000) begin
          compared++;
          if (exp_done.size() == 0) begin
            mismatched++;
            $display("FAIL done: got %b, required no pulse", done);
          end else begin
            ed = exp_done.pop_front();
            if (done !== ed) begin
              mismatched++;
              $display("FAIL done: got %b required %b", done, ed);
            end else $display("done ok   mask=%b cycle=%0d", done, cyc);
          end
        end
      end
      snd_prev = int'($signed(snd));
    end
  end

  task automatic send(input logic [1:0] ch, input logic st, input logic [15:0] a,
                      input logic [15:0] l, input logic [11:0] dv, input logic [1:0] v,
                      input logic lp);
    cmd_valid = 1'b1; cmd_chan = ch; cmd_start = st; cmd_addr = a;
    cmd_len = l; cmd_div = dv; cmd_vol = v; cmd_loop = lp;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drained(input string tag);
    check({tag, "_addr_left"}, exp_addr.size(), 0);
    check({tag, "_snd_left"},  exp_snd.size(), 0);
    check({tag, "_done_left"}, exp_done.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_chan = '0; cmd_start = 1'b0; cmd_addr = '0;
    cmd_len = '0; cmd_div = '0; cmd_vol = '0; cmd_loop = 1'b0;
    for (int i = 0; i < 65536; i++) rom[i] = 8'h80;
    rom[16'h0100] = 8'hFF; rom[16'h0101] = 8'h80; rom[16'h0102] = 8'h00; rom[16'h0103] = 8'h80;
    rom[16'h2000] = 8'h90; rom[16'h2001] = 8'hA0; rom[16'h2002] = 8'hB0;
    rom[16'h5000] = 8'hFF; rom[16'h3000] = 8'hC0;

    repeat (4) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_snd", int'($signed(snd)), 0);
    check("rst_rom_rd", int'(rom_rd), 0);
    check("rst_done", int'(done), 0);
    rst_n = 1'b1;
    idle(2);

    // Reset in the middle of looping playback of a full-scale byte
    send(2'd3, 1'b1, 16'h0100, 16'd1, 12'd11, 2'd3, 1'b1);
    idle(20);
    check("mid_busy", int'(busy[3]), 1);
    check("mid_snd", int'($signed(snd)), 24384);
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_snd", int'($signed(snd)), 0);
    check("post_rst_rom_rd", int'(rom_rd), 0);
    idle(3);
    mon_en = 1'b1;

    // One-shot ch0
    rd_times.delete();
    for (int i = 0; i < 4; i++) exp_addr.push_back(16'h0100 + 16'(i));
    exp_snd.push_back(24384); exp_snd.push_back(0);
    exp_snd.push_back(-24576); exp_snd.push_back(0);
    exp_done.push_back(4'b0001);
    send(2'd0, 1'b1, 16'h0100, 16'd4, 12'd99, 2'd3, 1'b0);
    idle(420);
    drained("oneshot");
    check("oneshot_busy0", int'(busy[0]), 0);
    check("oneshot_fetches", rd_times.size(), 4);
    if (rd_times.size() == 4)
      for (int i = 1; i < 4; i++) check("oneshot_spacing", rd_times[i] - rd_times[i-1], 100);

    // Looping ch1, stopped after ten periods
    rd_times.delete();
    for (int k = 0; k < 10; k++) begin
      exp_addr.push_back(16'h2000 + 16'(k % 3));
      exp_snd.push_back(((k % 3) + 1) * 1024);
    end
    send(2'd1, 1'b1, 16'h2000, 16'd3, 12'd49, 2'd1, 1'b1);
    idle(479);
    exp_snd.push_back(0);
    send(2'd1, 1'b0, 16'h0000, 16'd0, 12'd0, 2'd0, 1'b0);
    idle(20);
    drained("loop");
    check("loop_busy1", int'(busy[1]), 0);
    check("loop_fetches", rd_times.size(), 10);

    // Arbitration and saturation, positive then negative full scale
    for (int pass = 0; pass < 2; pass++) begin
      rd_times.delete();
      for (int c = 0; c < 4; c++) begin
        rom[16'h4000 + 16'(c * 16)] = (pass == 0) ? 8'hFF : 8'h00;
        exp_addr.push_back(16'h4000 + 16'(c * 16));
        exp_done.push_back(4'b0001 << c);
      end
      exp_snd.push_back((pass == 0) ? 24384 : -24576);
      exp_snd.push_back((pass == 0) ? 32767 : -32768);
      exp_snd.push_back((pass == 0) ? 24384 : -24576);
      exp_snd.push_back(0);
      for (int c = 0; c < 4; c++)
        send(2'(c), 1'b1, 16'h4000 + 16'(c * 16), 16'd1, 12'd199, 2'd3, 1'b0);
      idle(230);
      drained("arb");
      check("arb_fetches", rd_times.size(), 4);
      if (rd_times.size() == 4)
        for (int i = 1; i < 4; i++) check("arb_spacing", rd_times[i] - rd_times[i-1], 3);
    end

    // Restart ch2 exactly in its CAPTURE cycle
    exp_addr.push_back(16'h5000); exp_addr.push_back(16'h3000);
    exp_snd.push_back(4096); exp_snd.push_back(0);
    exp_done.push_back(4'b0100);
    send(2'd2, 1'b1, 16'h5000, 16'd4, 12'd99, 2'd1, 1'b0);
    idle(2);
    send(2'd2, 1'b1, 16'h3000, 16'd1, 12'd99, 2'd1, 1'b0);
    idle(130);
    drained("restart");
    check("restart_busy2", int'(busy[2]), 0);

    // LEN=0 start behaves as a stop
    send(2'd1, 1'b1, 16'h7000, 16'd0, 12'd20, 2'd3, 1'b0);
    idle(30);
    check("len0_busy1", int'(busy[1]), 0);
    check("len0_snd", int'($signed(snd)), 0);

    // Address wrap past the top of the ROM
    exp_addr.push_back(16'hFFFE); exp_addr.push_back(16'hFFFF);
    exp_addr.push_back(16'h0000); exp_addr.push_back(16'h0001);
    exp_done.push_back(4'b1000);
    send(2'd3, 1'b1, 16'hFFFE, 16'd4, 12'd11, 2'd0, 1'b0);
    idle(80);
    drained("wrap");
    check("wrap_busy3", int'(busy[3]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
